// File: rtl/if_id_skid_register_pkg.sv
// ----------------------------------------------------------------------------
// if_id_skid_register_pkg
//
// Shared pipeline definitions for the fetch/decode boundary and later pipeline
// registers.
//   occ_state_e    : occupancy of a two-entry skid register (empty/one/full).
//   FETCH_INSTR_W  : default instruction width.
//   FETCH_PC_W     : default PC width.
//   BUBBLE_INSTR_DEFAULT : instruction word used as a bubble (NOP encoding).
//   fetch_bundle_t : {instr, pc} pair at the default widths.
// ----------------------------------------------------------------------------
package if_id_skid_register_pkg;

    typedef enum logic [1:0] {
        OccEmpty = 2'd0,
        OccOne   = 2'd1,
        OccFull  = 2'd2
    } occ_state_e;

    localparam int unsigned FETCH_INSTR_W = 32;
    localparam int unsigned FETCH_PC_W    = 32;

    localparam logic [FETCH_INSTR_W-1:0] BUBBLE_INSTR_DEFAULT = '0;

    typedef struct packed {
        logic [FETCH_INSTR_W-1:0] instr;
        logic [FETCH_PC_W-1:0]    pc;
    } fetch_bundle_t;

endpackage

// File: rtl/if_id_skid_register.sv
// ----------------------------------------------------------------------------
// if_id_skid_register
//
// IF->ID pipeline register with a valid/ready handshake and a one-entry skid
// buffer, so in_ready can be a pure function of registered state without ever
// dropping an entry. One cycle latency, one instruction per cycle throughput.
// A flush empties the register and parks a bubble on the outputs.
//
// Ports:
//   clk        : clock, rising edge.
//   reset      : synchronous active-high reset (priority over flush).
//   flush      : discard all held entries and any entry offered this cycle.
//   in_valid   : IF offers in_instr / in_pc.
//   in_ready   : an entry can be accepted this cycle (registered).
//   in_instr   : fetched instruction.
//   in_pc      : PC of the fetched instruction.
//   out_valid  : out_instr / out_pc hold a live entry.
//   out_ready  : ID consumes the entry this cycle.
//   out_instr  : instruction to decode.
//   out_pc     : PC to decode.
// ----------------------------------------------------------------------------
module if_id_skid_register
    import if_id_skid_register_pkg::*;
#(
    parameter int unsigned         INSTR_W      = FETCH_INSTR_W,
    parameter int unsigned         PC_W         = FETCH_PC_W,
    parameter logic [INSTR_W-1:0]  BUBBLE_INSTR = INSTR_W'(BUBBLE_INSTR_DEFAULT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc
);

    // Same layout as fetch_bundle_t, sized by this instance's parameters.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } bundle_t;

    localparam bundle_t BUBBLE = '{instr: BUBBLE_INSTR, pc: '0};

    occ_state_e r_state;
    occ_state_e w_state_next;

    bundle_t r_main;
    bundle_t r_skid;
    bundle_t w_in;

    logic w_accept;
    logic w_pop;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    assign w_in     = '{instr: in_instr, pc: in_pc};
    assign w_accept = in_valid & in_ready;
    assign w_pop    = out_valid & out_ready;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= OccEmpty;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = OccEmpty;
        end else begin
            unique case (r_state)
                OccEmpty: begin
                    if (w_accept) w_state_next = OccOne;
                end
                OccOne: begin
                    if (w_accept && !w_pop) begin
                        w_state_next = OccFull;
                    end else if (!w_accept && w_pop) begin
                        w_state_next = OccEmpty;
                    end
                end
                OccFull: begin
                    if (w_pop) w_state_next = OccOne;
                end
                default: w_state_next = OccEmpty;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: handshake flags depend on registered state only
    // ------------------------------------------------------------------------
    always_comb begin
        in_ready  = (r_state != OccFull);
        out_valid = (r_state != OccEmpty);
    end

    assign out_instr = r_main.instr;
    assign out_pc    = r_main.pc;

    // ------------------------------------------------------------------------
    // Data path enables
    // ------------------------------------------------------------------------
    always_comb begin
        w_load_main_in   = w_accept &&
                           ((r_state == OccEmpty) || ((r_state == OccOne) && w_pop));
        w_load_skid      = w_accept && (r_state == OccOne) && !w_pop;
        w_load_main_skid = (r_state == OccFull) && w_pop;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_main <= BUBBLE;
        end else if (w_load_main_in) begin
            r_main <= w_in;
        end else if (w_load_main_skid) begin
            r_main <= r_skid;
        end
    end

    // A flush leaves stale skid data behind; it is unreachable until the
    // state machine passes through ONE again, which rewrites the skid first.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_skid <= BUBBLE;
        end else if (w_load_skid) begin
            r_skid <= w_in;
        end
    end

endmodule

// File: tb/tb_if_id_skid_register.sv
`timescale 1ns/1ps
module tb_if_id_skid_register;

    localparam logic [15:0] B_BUBBLE = 16'h0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic flush = 1'b0;

    // Default-width instance
    logic        a_in_valid  = 1'b0;
    logic        a_in_ready;
    logic [31:0] a_in_instr  = '0;
    logic [31:0] a_in_pc     = '0;
    logic        a_out_valid;
    logic        a_out_ready = 1'b1;
    logic [31:0] a_out_instr;
    logic [31:0] a_out_pc;

    // Narrow instance with a non-zero bubble
    logic        b_in_valid  = 1'b0;
    logic        b_in_ready;
    logic [15:0] b_in_instr  = '0;
    logic [11:0] b_in_pc     = '0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b1;
    logic [15:0] b_out_instr;
    logic [11:0] b_out_pc;

    if_id_skid_register u_dut_a (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_instr  (a_in_instr),
        .in_pc     (a_in_pc),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_instr (a_out_instr),
        .out_pc    (a_out_pc)
    );

    if_id_skid_register #(
        .INSTR_W      (16),
        .PC_W         (12),
        .BUBBLE_INSTR (B_BUBBLE)
    ) u_dut_b (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_instr  (b_in_instr),
        .in_pc     (b_in_pc),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_instr (b_out_instr),
        .out_pc    (b_out_pc)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] a_q[$];
    logic [27:0] b_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitors: every pop at ID must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && a_out_valid === 1'b1 && a_out_ready) begin
            if (a_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL a_pop_unexpected: got %h/%h, expected no entry",
                         a_out_instr, a_out_pc);
            end else begin
                check("a_pop_data", {a_out_instr, a_out_pc}, a_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && b_out_valid === 1'b1 && b_out_ready) begin
            if (b_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL b_pop_unexpected: got %h/%h, expected no entry",
                         b_out_instr, b_out_pc);
            end else begin
                check("b_pop_data", 64'({b_out_instr, b_out_pc}), 64'(b_q.pop_front()));
            end
        end
    end

    // One clock of stimulus; called just after a rising edge.
    task automatic cycle_a(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                           input logic ordy, input logic fl);
        a_in_valid  = v;
        a_in_instr  = instr;
        a_in_pc     = pc;
        a_out_ready = ordy;
        flush       = fl;
        if (v && a_in_ready && !fl && !reset) a_q.push_back({instr, pc});
        @(posedge clk);
        #1;
        if (fl || reset) begin
            a_q.delete();
            b_q.delete();
        end
        flush = 1'b0;
    endtask

    task automatic cycle_b(input logic v, input logic [15:0] instr, input logic [11:0] pc,
                           input logic ordy, input logic fl);
        b_in_valid  = v;
        b_in_instr  = instr;
        b_in_pc     = pc;
        b_out_ready = ordy;
        flush       = fl;
        if (v && b_in_ready && !fl && !reset) b_q.push_back({instr, pc});
        @(posedge clk);
        #1;
        if (fl || reset) begin
            a_q.delete();
            b_q.delete();
        end
        flush = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset values
        check("rst_a_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_a_in_ready", 64'(a_in_ready), 64'd1);
        check("rst_a_out_instr", 64'(a_out_instr), 64'd0);
        check("rst_a_out_pc", 64'(a_out_pc), 64'd0);
        check("rst_b_out_instr", 64'(b_out_instr), 64'(B_BUBBLE));
        check("rst_b_out_pc", 64'(b_out_pc), 64'd0);

        // Streaming with ID always ready: no gaps, in_ready stays high
        cycle_a(1'b1, 32'h11, 32'h0, 1'b1, 1'b0);
        check("stream_valid0", 64'(a_out_valid), 64'd1);
        check("stream_ready0", 64'(a_in_ready), 64'd1);
        cycle_a(1'b1, 32'h22, 32'h4, 1'b1, 1'b0);
        check("stream_valid1", 64'(a_out_valid), 64'd1);
        check("stream_ready1", 64'(a_in_ready), 64'd1);
        cycle_a(1'b1, 32'h33, 32'h8, 1'b1, 1'b0);
        check("stream_valid2", 64'(a_out_valid), 64'd1);
        check("stream_instr2", 64'(a_out_instr), 64'h33);
        cycle_a(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("stream_drained", 64'(a_out_valid), 64'd0);

        // Fill to FULL with ID stalled, then drain; B3 waits for in_ready
        cycle_a(1'b1, 32'hA1, 32'h100, 1'b0, 1'b0);
        cycle_a(1'b1, 32'hA2, 32'h104, 1'b0, 1'b0);
        check("full_in_ready", 64'(a_in_ready), 64'd0);
        check("full_out_instr", 64'(a_out_instr), 64'hA1);
        cycle_a(1'b1, 32'hB3, 32'h108, 1'b0, 1'b0);
        check("stall_in_ready", 64'(a_in_ready), 64'd0);
        cycle_a(1'b1, 32'hB3, 32'h108, 1'b1, 1'b0);
        check("skid_in_ready_back", 64'(a_in_ready), 64'd1);
        check("skid_out_instr", 64'(a_out_instr), 64'hA2);
        check("skid_out_pc", 64'(a_out_pc), 64'h104);
        cycle_a(1'b1, 32'hB3, 32'h108, 1'b1, 1'b0);
        check("b3_out_instr", 64'(a_out_instr), 64'hB3);
        cycle_a(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("skid_drained", 64'(a_out_valid), 64'd0);

        // Flush while FULL with in_valid high
        cycle_a(1'b1, 32'hC1, 32'h200, 1'b0, 1'b0);
        cycle_a(1'b1, 32'hC2, 32'h204, 1'b0, 1'b0);
        cycle_a(1'b1, 32'hC3, 32'h208, 1'b0, 1'b1);
        check("flush_out_valid", 64'(a_out_valid), 64'd0);
        check("flush_in_ready", 64'(a_in_ready), 64'd1);
        check("flush_out_instr", 64'(a_out_instr), 64'd0);
        check("flush_out_pc", 64'(a_out_pc), 64'd0);

        // Flush from ONE: the pop of D1 still counts, D2 is discarded
        cycle_a(1'b1, 32'hD1, 32'h300, 1'b0, 1'b0);
        cycle_a(1'b1, 32'hD2, 32'h304, 1'b1, 1'b1);
        check("flush1_out_valid", 64'(a_out_valid), 64'd0);
        cycle_a(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle_a(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("flush1_stays_empty", 64'(a_out_valid), 64'd0);

        // Reset together with flush while FULL
        cycle_a(1'b1, 32'hE1, 32'h400, 1'b0, 1'b0);
        cycle_a(1'b1, 32'hE2, 32'h404, 1'b0, 1'b0);
        reset = 1'b1;
        cycle_a(1'b1, 32'hE3, 32'h408, 1'b1, 1'b1);
        reset = 1'b0;
        check("rstmid_out_valid", 64'(a_out_valid), 64'd0);
        check("rstmid_in_ready", 64'(a_in_ready), 64'd1);
        check("rstmid_out_instr", 64'(a_out_instr), 64'd0);
        check("rstmid_out_pc", 64'(a_out_pc), 64'd0);
        cycle_a(1'b1, 32'hF1, 32'h500, 1'b1, 1'b0);
        check("recover_instr", 64'(a_out_instr), 64'hF1);
        cycle_a(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Narrow instance: widths carried exactly
        cycle_b(1'b1, 16'h1234, 12'h004, 1'b1, 1'b0);
        check("b_stream_valid0", 64'(b_out_valid), 64'd1);
        cycle_b(1'b1, 16'hABCD, 12'h008, 1'b1, 1'b0);
        check("b_stream_valid1", 64'(b_out_valid), 64'd1);
        cycle_b(1'b1, 16'hFFFF, 12'hFFC, 1'b1, 1'b0);
        check("b_stream_instr2", 64'(b_out_instr), 64'hFFFF);
        check("b_stream_pc2", 64'(b_out_pc), 64'hFFC);
        cycle_b(1'b0, 16'h0, 12'h0, 1'b1, 1'b0);
        check("b_stream_drained", 64'(b_out_valid), 64'd0);

        // Narrow instance flush loads its own bubble
        cycle_b(1'b1, 16'h5555, 12'h010, 1'b0, 1'b0);
        check("b_hold_instr", 64'(b_out_instr), 64'h5555);
        cycle_b(1'b0, 16'h0, 12'h0, 1'b0, 1'b1);
        check("b_flush_valid", 64'(b_out_valid), 64'd0);
        check("b_flush_instr", 64'(b_out_instr), 64'(B_BUBBLE));
        check("b_flush_pc", 64'(b_out_pc), 64'd0);
        cycle_b(1'b0, 16'h0, 12'h0, 1'b1, 1'b0);

        check("a_queue_drained", 64'(a_q.size()), 64'd0);
        check("b_queue_drained", 64'(b_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/if_id_skid_register.md
# if_id_skid_register

Parametrised fetch-to-decode pipeline register carrying instruction and PC between the IF and ID stages. Adds a valid/ready handshake, a one-entry skid buffer so that the registered `in_ready` never drops data, and a flush that inserts a bubble on branch redirect. Latency is one cycle and throughput is one instruction per cycle. It is the generalised successor of the plain reset/capture IF/ID register.

## Interface
- `INSTR_W`, default 32: instruction width in bits.
- `PC_W`, default 32: PC width in bits.
- `BUBBLE_INSTR`, default 0: value loaded into `out_instr` on reset and flush.

Ports (name, direction, width, meaning):
- `clk`, input, 1: clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `flush`, input, 1: synchronous discard of all held entries.
- `in_valid`, input, 1: the IF stage offers `in_instr` and `in_pc`.
- `in_ready`, output, 1: the block can accept an entry this cycle.
- `in_instr`, input, `INSTR_W`: fetched instruction.
- `in_pc`, input, `PC_W`: PC of the fetched instruction.
- `out_valid`, output, 1: `out_instr` and `out_pc` hold a live entry.
- `out_ready`, input, 1: the ID stage consumes the entry this cycle.
- `out_instr`, output, `INSTR_W`: instruction to decode.
- `out_pc`, output, `PC_W`: PC to decode.

## Operation
- Handshake events:
  - accept = `in_valid & in_ready`
  - pop = `out_valid & out_ready`
- Storage is a main register, which drives the outputs, plus a skid register. Occupancy state is EMPTY, ONE or FULL.
- `in_ready` = (state != FULL). It depends only on state and has no combinational path from `out_ready`.
- `out_valid` = (state != EMPTY).
- State transitions:
  - EMPTY: on accept, main <= in and go to ONE; otherwise stay EMPTY.
  - ONE:
    - accept & pop: main <= in, stay ONE.
    - accept & !pop: skid <= in, go to FULL.
    - !accept & pop: go to EMPTY; main data is unchanged.
    - Neither event: hold.
  - FULL: no accept is possible. On pop, main <= skid and go to ONE; otherwise hold.
- Ordering is strict FIFO; no entry is duplicated or dropped except by flush.
- `flush`:
  - Next state is EMPTY.
  - `out_instr` <= `BUBBLE_INSTR`, `out_pc` <= 0, skid contents are don't-care.
  - An input accepted in the same cycle as `flush` is discarded.
  - `flush` overrides accept and pop. The pop handshake in that cycle still counts at ID, because the entry was presented.
- `reset` has priority over `flush`. Reset values:
  - state EMPTY
  - `out_valid` 0
  - `in_ready` 1 after the first post-reset edge
  - `out_instr` = `BUBBLE_INSTR`
  - `out_pc` 0
- Reset mid-operation drops all entries. No arithmetic is performed; all data paths are width-exact.

## Timing
- Accept in cycle N means the data is visible on the outputs in cycle N+1 when the block was EMPTY, or ONE with a pop.
- A skidded entry reaches the outputs one cycle after the pop of the entry ahead of it.
- `in_ready` falls in the cycle after the accept that fills FULL, and rises in the cycle after the pop from FULL.
- A flush in cycle N gives `out_valid`=0 and `in_ready`=1 in cycle N+1.
- The first valid output after reset is at earliest one cycle after the first accept.

## Structure
- Shared pipeline package holds:
  - the occupancy state enum (EMPTY, ONE, FULL)
  - the `BUBBLE_INSTR` default constant (NOP encoding)
  - a `fetch_bundle` struct {instr, pc} reused by the later pipeline registers
- No sub-module: a single always block for state plus the two data registers. The `fetch_bundle` struct lets both registers be written as one assignment each.

## Test plan
- Reset, then stream 0x11,0x22,0x33 at PCs 0,4,8 with `out_ready`=1 -> the same sequence appears one cycle later, `in_ready` stays 1, no gaps.
- Accept 0xA1 and 0xA2 with `out_ready`=0 -> FULL, `in_ready`=0. Then raise `out_ready` -> 0xA1, then 0xA2, in order, with no loss; `in_ready` returns to 1 one cycle after the first pop.
- FULL with `in_valid` held at 0xB3 during the stall -> 0xB3 is not accepted until `in_ready`=1, then appears after 0xA2.
- Assert `flush` while FULL and `in_valid`=1 -> next cycle `out_valid`=0, `out_instr`=`BUBBLE_INSTR`, `out_pc`=0, and the flushed-cycle input never appears.
- Assert `reset` and `flush` together mid-stream -> reset values are taken. With `INSTR_W`=16 and `PC_W`=12, repeat the streaming scenario -> widths are carried exactly.
